alu_mc: RTL and testbench

Parametrised multi-cycle ALU with valid/ready handshakes on its input and output sides. Single-cycle ops (logic, shifts, add/sub, compares) produce a registered result one cycle after accept. MUL runs an iterative shift-add multiplier, one multiplier bit per cycle. It sits between the decode/operand stage and writeback of the multi-cycle CPU datapath.

---
 rtl/alu_mc_pkg.sv | 31 +++
 rtl/alu_mc_core.sv | 53 +++++
 rtl/alu_mc.sv | 166 ++++++++++++++++
 tb/tb_alu_mc.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_mc_pkg.sv
// Shared types for the multi-cycle ALU: opcode and FSM state enums.
// ALU_MC_MULHU_EN enables the upper-half unsigned multiply (opcode 9).
package alu_types;

  typedef enum logic [3:0] {
    ALU_AND   = 4'd1,
    ALU_OR    = 4'd2,
    ALU_XOR   = 4'd3,
    ALU_MUL   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_ADD   = 4'd8,
    ALU_MULHU = 4'd9,
    ALU_SUB   = 4'd12,
    ALU_SLT   = 4'd13,
    ALU_SLTU  = 4'd15
  } alu_control_t;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} alu_mc_state_t;

  // Opcodes that take the iterative multiplier path instead of the 1-cycle core.
  function automatic logic is_mul_op(input logic [3:0] op);
`ifdef ALU_MC_MULHU_EN
    return (op == ALU_MUL) || (op == ALU_MULHU);
`else
    return op == ALU_MUL;
`endif
  endfunction

endpackage

// File: rtl/alu_mc_core.sv
// Combinational single-cycle datapath: logic, shifts, add/sub, compares.
// Multiply opcodes and unsupported codes yield result=0 here.
module alu_core
  import alu_types::*;
#(
  parameter  int N   = 32,
  localparam int SHW = $clog2(N)
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   control,
  output logic [N-1:0] result,
  output logic         overflow,
  output logic         zero,
  output logic         equal
);

  logic [N-1:0]   sum;
  logic [N-1:0]   diff;
  logic [SHW-1:0] shamt;

  assign sum   = a + b;
  assign diff  = a - b;
  assign shamt = b[SHW-1:0];

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (control)
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << shamt;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $signed(a) >>> shamt;
      ALU_ADD: begin
        result   = sum;
        overflow = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
      end
      ALU_SUB: begin
        result   = diff;
        overflow = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
      end
      ALU_SLT:  result = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(N-1){1'b0}}, (a < b)};
      default:  result = '0;
    endcase
  end

  assign zero  = (result == '0);
  assign equal = (a == b);

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready on both sides; MUL is an N-step shift-add.
// Define ALU_MC_MULHU_EN to add MULHU (upper half of the 2N-bit product).
module alu_mc
  import alu_types::*;
#(
  parameter  int N   = 32,
  localparam int SHW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   control,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         overflow,
  output logic         zero,
  output logic         equal
);

`ifdef ALU_MC_MULHU_EN
  localparam int PW = 2 * N;
`else
  localparam int PW = N;
`endif
  localparam logic [SHW-1:0] CNT_LAST = SHW'(N - 1);

  alu_mc_state_t state_q, state_d;

  logic [N-1:0]   result_q, result_d;
  logic           overflow_q, overflow_d;
  logic           zero_q, zero_d;
  logic           equal_q, equal_d;
  logic [PW-1:0]  mcand_q, mcand_d;
  logic [PW-1:0]  prod_q, prod_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [SHW-1:0] cnt_q, cnt_d;

  logic [N-1:0]   core_result;
  logic           core_overflow;
  logic           core_zero;
  logic           core_equal;
  logic           accept;
  logic           start_mul;
  logic           mul_last;
  logic [PW-1:0]  prod_step;
  logic [N-1:0]   mul_res;

  alu_core #(.N(N)) u_core (
    .a        (a),
    .b        (b),
    .control  (control),
    .result   (core_result),
    .overflow (core_overflow),
    .zero     (core_zero),
    .equal    (core_equal)
  );

  assign accept    = in_valid && in_ready;
  assign start_mul = accept && is_mul_op(control);
  assign mul_last  = (state_q == S_MUL) && (cnt_q == CNT_LAST);
  assign prod_step = mplier_q[0] ? (prod_q + mcand_q) : prod_q;

`ifdef ALU_MC_MULHU_EN
  logic hi_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            hi_q <= 1'b0;
    else if (start_mul) hi_q <= (control == ALU_MULHU);
  end

  assign mul_res = hi_q ? prod_step[PW-1:N] : prod_step[N-1:0];
`else
  assign mul_res = prod_step;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid) state_d = is_mul_op(control) ? S_MUL : S_DONE;
      S_MUL:  if (mul_last) state_d = S_DONE;
      S_DONE: begin
        if (out_ready) begin
          if (in_valid) state_d = is_mul_op(control) ? S_MUL : S_DONE;
          else          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    out_valid = (state_q == S_DONE);
  end

  // Operand/result datapath; a new accept always overrides the held result.
  always_comb begin
    result_d   = result_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
    equal_d    = equal_q;
    mcand_d    = mcand_q;
    prod_d     = prod_q;
    mplier_d   = mplier_q;
    cnt_d      = cnt_q;
    if (start_mul) begin
      mcand_d  = PW'(a);
      mplier_d = b;
      prod_d   = '0;
      cnt_d    = '0;
      equal_d  = core_equal;
    end else if (accept) begin
      result_d   = core_result;
      overflow_d = core_overflow;
      zero_d     = core_zero;
      equal_d    = core_equal;
    end else if (state_q == S_MUL) begin
      prod_d   = prod_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + SHW'(1);
      if (mul_last) begin
        result_d   = mul_res;
        overflow_d = 1'b0;
        zero_d     = (mul_res == '0);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q   <= '0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      equal_q    <= 1'b0;
      mcand_q    <= '0;
      prod_q     <= '0;
      mplier_q   <= '0;
      cnt_q      <= '0;
    end else begin
      result_q   <= result_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
      equal_q    <= equal_d;
      mcand_q    <= mcand_d;
      prod_q     <= prod_d;
      mplier_q   <= mplier_d;
      cnt_q      <= cnt_d;
    end
  end

  assign result   = result_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;
  assign equal    = equal_q;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc (N=32): directed vectors queued at issue,
// checked by a monitor on each output handshake, including latency.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  control;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        zero;
  logic        equal;

  alu_mc #(.N(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .control   (control),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .zero      (zero),
    .equal     (equal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        ov;
    logic        z;
    logic        eq;
    int          lat;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;
  int   next_id = 0;
  bit   seen_first = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s (txn %0d): got %h, expected %h", name, id, act, want);
  endtask

  // Drive one op (called just after a rising edge); returns just after the accept edge.
  task automatic send(input logic [3:0] op, input logic [31:0] aa, input logic [31:0] bb,
                      input logic [31:0] er, input logic eov, input logic ez, input logic eeq,
                      input int elat, input bit push);
    exp_t e;
    int   waited = 0;
    control  = op;
    a        = aa;
    b        = bb;
    in_valid = 1'b1;
    if (push) begin
      e.res = er; e.ov = eov; e.z = ez; e.eq = eeq; e.lat = elat; e.id = next_id;
      next_id++;
      exp_q.push_back(e);
    end
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) chk("send_timeout", next_id, {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      waited++;
      @(posedge clk);
    end
    chk("drain_timeout", -1, exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: latency on first valid, full compare on handshake.
  initial begin
    exp_t e;
    int   acc;
    forever begin
      @(negedge clk);
      if (rst) begin
        acc_q.delete();
        seen_first = 0;
      end else begin
        if (in_valid && in_ready) acc_q.push_back(cyc + 1);
        if (out_valid && !seen_first) begin
          seen_first = 1;
          if (exp_q.size() == 0 || acc_q.size() == 0) begin
            chk("unexpected_valid", -1, {31'b0, out_valid}, 32'd0);
          end else begin
            acc = acc_q.pop_front();
            chk("latency", exp_q[0].id, cyc - acc + 1, exp_q[0].lat);
          end
        end
        if (out_valid && out_ready && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          $display("txn %0d: result=%h ovf=%b zero=%b eq=%b", e.id, result, overflow, zero, equal);
          chk("result", e.id, result, e.res);
          chk("overflow", e.id, {31'b0, overflow}, {31'b0, e.ov});
          chk("zero", e.id, {31'b0, zero}, {31'b0, e.z});
          chk("equal", e.id, {31'b0, equal}, {31'b0, e.eq});
          seen_first = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v_cnt;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; control = '0;
    @(negedge clk);
    chk("rst_out_valid", -1, {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", -1, {31'b0, in_ready}, 32'd1);
    chk("rst_result", -1, result, 32'd0);
    chk("rst_flags", -1, {29'b0, overflow, zero, equal}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    //      op     a             b             result        ov    z     eq    lat
    send(4'd8,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0, 1'b0, 1, 1);
    send(4'd12, 32'd5,        32'd5,        32'h00000000, 1'b0, 1'b1, 1'b1, 1, 1);
    send(4'd13, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1, 1);
    send(4'd15, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b0, 1, 1);
    send(4'd12, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1, 1);
    send(4'd1,  32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1'b0, 1'b0, 1'b0, 1, 1);
    send(4'd2,  32'h00000F00, 32'h000000F0, 32'h00000FF0, 1'b0, 1'b0, 1'b0, 1, 1);
    send(4'd5,  32'h00000001, 32'h00000025, 32'h00000020, 1'b0, 1'b0, 1'b0, 1, 1);
    send(4'd6,  32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, 1'b0, 1'b0, 1, 1);
    send(4'd0,  32'h00000007, 32'h00000007, 32'h00000000, 1'b0, 1'b1, 1'b1, 1, 1);

    send(4'd4,  32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 33, 1);
    @(negedge clk);
    chk("mul_busy_in_ready", -1, {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    send(4'd4,  32'h00000003, 32'h00000003, 32'h00000009, 1'b0, 1'b0, 1'b1, 33, 1);
    drain();

    // Backpressure: result must hold while the consumer stalls.
    out_ready = 1'b0;
    send(4'd7,  32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, 1'b0, 1'b0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", i, {31'b0, out_valid}, 32'd1);
      chk("bp_in_ready", i, {31'b0, in_ready}, 32'd0);
      chk("bp_result", i, result, 32'hF8000000);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(4'd3,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0, 1, 1);
    drain();

    // Reset during a multiply discards it.
    send(4'd4,  32'h12345678, 32'h9ABCDEF0, 32'h0, 1'b0, 1'b0, 1'b0, 33, 0);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    v_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) v_cnt++;
    end
    chk("no_valid_after_rst", -1, v_cnt, 32'd0);
    chk("rst_idle_in_ready", -1, {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    send(4'd8,  32'd2,        32'd3,        32'd5,        1'b0, 1'b0, 1'b0, 1, 1);

`ifdef ALU_MC_MULHU_EN
    send(4'd9,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 33, 1);
`else
    send(4'd9,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b1, 1, 1);
`endif
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
